// File: rtl/encoder_8to3_seq.sv
//------------------------------------------------------------------------------
// Module   : encoder_8to3_seq
// Brief    : Snapshots eight active-low request lines and emits the index of
//            each asserted line, one per valid/ready handshake, in priority order.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module encoder_8to3_seq #(
    parameter int PRIORITY_LSB = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] Y,
    output logic       load_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       last,
    output logic [3:0] remaining
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_pending;
    logic [7:0] w_pending_nxt;
    logic [2:0] w_idx;
    logic [3:0] w_count;

    // The last matching bit visited wins, so the scan direction sets the priority.
    generate
        if (PRIORITY_LSB != 0) begin : g_lsb
            always_comb begin
                w_idx = 3'd0;
                for (int i = 7; i >= 0; i--) begin
                    if (r_pending[i]) w_idx = 3'(i);
                end
            end
        end else begin : g_msb
            always_comb begin
                w_idx = 3'd0;
                for (int i = 0; i < 8; i++) begin
                    if (r_pending[i]) w_idx = 3'(i);
                end
            end
        end
    endgenerate

    always_comb begin
        w_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_count = w_count + {3'd0, r_pending[i]};
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        case (r_state)
            IDLE: begin
                if (en && (Y != 8'hFF)) begin
                    w_pending_nxt = ~Y;
                    w_state_nxt   = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    w_pending_nxt = r_pending & ~(8'h01 << w_idx);
                    if (w_count == 4'd1) w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_pending_nxt = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // Outputs depend only on registered state, never on the live inputs.
    assign load_ready = (r_state == IDLE);
    assign out_valid  = (r_state == EMIT);
    assign {A, B, C}  = (r_state == EMIT) ? w_idx : 3'b000;
    assign remaining  = (r_state == EMIT) ? w_count : 4'd0;
    assign last       = (r_state == EMIT) && (w_count == 4'd1);

endmodule

`default_nettype wire

// File: tb/tb_encoder_8to3_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_encoder_8to3_seq
// Brief    : Scoreboard bench for encoder_8to3_seq, both priority orders in parallel.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_encoder_8to3_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] Y;
    logic       out_ready;

    logic       lr_a, ov_a, a_a, b_a, c_a, last_a;
    logic [3:0] rem_a;
    logic       lr_d, ov_d, a_d, b_d, c_d, last_d;
    logic [3:0] rem_d;

    int checks   = 0;
    int failures = 0;

    logic [2:0] q_asc[$];
    logic [2:0] q_desc[$];

    encoder_8to3_seq #(.PRIORITY_LSB(1)) dut_asc (
        .clk(clk), .reset(reset), .en(en), .Y(Y),
        .load_ready(lr_a), .out_valid(ov_a), .out_ready(out_ready),
        .A(a_a), .B(b_a), .C(c_a), .last(last_a), .remaining(rem_a)
    );

    encoder_8to3_seq #(.PRIORITY_LSB(0)) dut_desc (
        .clk(clk), .reset(reset), .en(en), .Y(Y),
        .load_ready(lr_d), .out_valid(ov_d), .out_ready(out_ready),
        .A(a_d), .B(b_d), .C(c_d), .last(last_d), .remaining(rem_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of the downstream active-low 3-to-8 decoder with en=1.
    function automatic logic [7:0] dec3to8(input logic [2:0] code);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << code);
    endfunction

    task automatic check_one(input string nm, input logic [2:0] q[$],
                             input logic lr, input logic ov, input logic [2:0] code,
                             input logic lst, input logic [3:0] rem);
        int n;
        n = q.size();
        chk({nm, ".out_valid"},  {7'd0, ov}, {7'd0, (n != 0)});
        chk({nm, ".load_ready"}, {7'd0, lr}, {7'd0, (n == 0)});
        chk({nm, ".remaining"},  {4'd0, rem}, 8'(n));
        chk({nm, ".last"},       {7'd0, lst}, {7'd0, (n == 1)});
        if (n != 0) begin
            chk({nm, ".code"},    {5'd0, code}, {5'd0, q[0]});
            chk({nm, ".decoded"}, dec3to8(code), dec3to8(q[0]));
        end else begin
            chk({nm, ".idle_code"}, {5'd0, code}, 8'h00);
        end
    endtask

    // One clock: drive inputs, compare current outputs, update the model, advance.
    task automatic cycle(input logic rst_v, input logic en_v, input logic [7:0] y_v,
                         input logic rdy_v);
        logic       cap;
        logic [7:0] req;
        reset     = rst_v;
        en        = en_v;
        Y         = y_v;
        out_ready = rdy_v;
        check_one("asc",  q_asc,  lr_a, ov_a, {a_a, b_a, c_a}, last_a, rem_a);
        check_one("desc", q_desc, lr_d, ov_d, {a_d, b_d, c_d}, last_d, rem_d);
        cap = (q_asc.size() == 0) && en_v && (y_v != 8'hFF);
        req = ~y_v;
        if (rst_v) begin
            q_asc.delete();
            q_desc.delete();
        end else if (q_asc.size() != 0) begin
            if (rdy_v) begin
                void'(q_asc.pop_front());
                void'(q_desc.pop_front());
            end
        end else if (cap) begin
            for (int i = 0; i < 8; i++) if (req[i]) q_asc.push_back(3'(i));
            for (int i = 7; i >= 0; i--) if (req[i]) q_desc.push_back(3'(i));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; Y = 8'hFF; out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // No capture when every line is idle.
        cycle(1'b0, 1'b0, 8'hFF, 1'b0);
        repeat (3) cycle(1'b0, 1'b1, 8'hFF, 1'b1);

        // Single request.
        cycle(1'b0, 1'b1, 8'b1111_1011, 1'b1);
        cycle(1'b0, 1'b0, 8'hFF, 1'b1);
        cycle(1'b0, 1'b0, 8'hFF, 1'b1);

        // Three requests; en on the final handshake must be ignored.
        cycle(1'b0, 1'b1, 8'b0101_1110, 1'b1);
        cycle(1'b0, 1'b0, 8'hFF, 1'b1);
        cycle(1'b0, 1'b0, 8'hFF, 1'b1);
        cycle(1'b0, 1'b1, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'hFF, 1'b1);

        // Back-pressure while en and Y wiggle.
        cycle(1'b0, 1'b1, 8'b1110_0111, 1'b0);
        for (int k = 0; k < 4; k++)
            cycle(1'b0, k[0], 8'($urandom_range(0, 255)), 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 8'hFF, 1'b1);

        // Full snapshot drains in eight cycles.
        cycle(1'b0, 1'b1, 8'h00, 1'b1);
        repeat (9) cycle(1'b0, 1'b0, 8'hFF, 1'b1);

        // Reset mid-drain discards the snapshot.
        cycle(1'b0, 1'b1, 8'h00, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 8'hFF, 1'b1);
        cycle(1'b1, 1'b0, 8'hFF, 1'b1);
        cycle(1'b0, 1'b1, 8'b1111_1101, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 8'hFF, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
